// File: rtl/pcie_link_mon_pkg.sv
// rtl/pcie_link_mon_pkg.sv - state encodings, default parameters and width helper for the PCIe link monitor
package pcie_link_mon_pkg;

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_DEB  = 3'd1;
    localparam logic [2:0] ST_RST  = 3'd2;
    localparam logic [2:0] ST_UP   = 3'd3;
    localparam logic [2:0] ST_TMO  = 3'd4;

    localparam int DEF_DEBOUNCE_CYC  = 16;
    localparam int DEF_USR_RST_CYC   = 64;
    localparam int DEF_TRAIN_TMO_CYC = 1000000;
    localparam int DEF_CNT_W         = 8;

    // Bits needed for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pcie_sync2.sv
// rtl/pcie_sync2.sv - two-flop synchronizer with asynchronous active-high reset to a parameterised value
module pcie_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_link_mon.sv
// rtl/pcie_link_mon.sv - PCIe link monitor: debounced link_ok, sequenced user reset, training timeout; drop counter under PCIE_LNKMON_CNT_EN
module pcie_link_mon
    import pcie_link_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int USR_RST_CYC   = DEF_USR_RST_CYC,
    parameter int TRAIN_TMO_CYC = DEF_TRAIN_TMO_CYC,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             pciexp_refclk_i,
    input  logic             rst_i,
    input  logic             trn_lnk_up_n_i,
    input  logic             module_rdy_i,
    input  logic             usr_rst_req_i,
    output logic             usr_rst_o,
    output logic             link_ok_o,
    output logic             train_tmo_o,
    output logic             sys_reset_req_o,
    output logic [CNT_W-1:0] lnk_down_cnt_o
);

    localparam int DEB_W = cnt_width(DEBOUNCE_CYC);
    localparam int RST_W = cnt_width(USR_RST_CYC);
    localparam int TMO_W = cnt_width(TRAIN_TMO_CYC);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(USR_RST_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TRAIN_TMO_CYC - 1);

    logic lnk_n_sync;
    logic rdy_sync;
    logic link_up_s;

    // Both synchronizers come out of reset reporting the link as down.
    pcie_sync2 #(.RST_VAL(1'b1)) u_sync_lnk (
        .clk (pciexp_refclk_i),
        .rst (rst_i),
        .d   (trn_lnk_up_n_i),
        .q   (lnk_n_sync)
    );

    pcie_sync2 #(.RST_VAL(1'b0)) u_sync_rdy (
        .clk (pciexp_refclk_i),
        .rst (rst_i),
        .d   (module_rdy_i),
        .q   (rdy_sync)
    );

    assign link_up_s = ~lnk_n_sync & rdy_sync;

    logic [2:0]       state, state_nxt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_hit;
    logic             tmo_pulse;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // tmo_cnt saturates at its terminal value so a long debounce/reset phase cannot wrap it.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        rst_cnt_nxt = rst_cnt;
        tmo_cnt_nxt = tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;
        tmo_pulse   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (link_up_s) begin
                    state_nxt   = ST_DEB;
                    deb_cnt_nxt = '0;
                end else if (tmo_hit) begin
                    state_nxt   = ST_TMO;
                    tmo_cnt_nxt = '0;
                    tmo_pulse   = 1'b1;
                end
            end
            ST_DEB: begin
                if (!link_up_s) begin
                    state_nxt = ST_WAIT;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = ST_RST;
                    rst_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            ST_RST: begin
                if (!link_up_s) begin
                    state_nxt = ST_WAIT;
                end else if (rst_cnt == RST_LAST) begin
                    state_nxt   = ST_UP;
                    tmo_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            ST_UP: begin
                tmo_cnt_nxt = '0;
                if (!link_up_s) begin
                    state_nxt = ST_WAIT;
                end else if (usr_rst_req_i) begin
                    state_nxt   = ST_RST;
                    rst_cnt_nxt = '0;
                end
            end
            ST_TMO: begin
                if (link_up_s) begin
                    state_nxt   = ST_DEB;
                    deb_cnt_nxt = '0;
                end else if (tmo_hit) begin
                    tmo_cnt_nxt = '0;
                    tmo_pulse   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge pciexp_refclk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= ST_WAIT;
            deb_cnt         <= '0;
            rst_cnt         <= '0;
            tmo_cnt         <= '0;
            usr_rst_o       <= 1'b1;
            link_ok_o       <= 1'b0;
            train_tmo_o     <= 1'b0;
            sys_reset_req_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            deb_cnt         <= deb_cnt_nxt;
            rst_cnt         <= rst_cnt_nxt;
            tmo_cnt         <= tmo_cnt_nxt;
            usr_rst_o       <= (state_nxt != ST_UP);
            link_ok_o       <= (state_nxt == ST_UP);
            sys_reset_req_o <= tmo_pulse;
            if (state_nxt == ST_UP && state != ST_UP) begin
                train_tmo_o <= 1'b0;
            end else if (tmo_pulse) begin
                train_tmo_o <= 1'b1;
            end
        end
    end

`ifdef PCIE_LNKMON_CNT_EN
    logic lnk_drop;

    assign lnk_drop = (state == ST_UP) & ~link_up_s;

    always_ff @(posedge pciexp_refclk_i or posedge rst_i) begin
        if (rst_i) begin
            lnk_down_cnt_o <= '0;
        end else if (lnk_drop && (lnk_down_cnt_o != {CNT_W{1'b1}})) begin
            lnk_down_cnt_o <= lnk_down_cnt_o + 1'b1;
        end
    end
`else
    assign lnk_down_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pcie_link_mon.sv
// tb/tb_pcie_link_mon.sv - directed self-checking bench for pcie_link_mon
module tb_pcie_link_mon;
    import pcie_link_mon_pkg::*;

    logic       clk;
    logic       rst;
    logic       lnk_n;
    logic       rdy;
    logic       req;
    logic       usr_rst;
    logic       link_ok;
    logic       train_tmo;
    logic       sys_req;
    logic [7:0] cnt;

    int n_asrt = 0;
    int n_fail = 0;

    pcie_link_mon #(
        .DEBOUNCE_CYC  (16),
        .USR_RST_CYC   (64),
        .TRAIN_TMO_CYC (200),
        .CNT_W         (8)
    ) dut (
        .pciexp_refclk_i (clk),
        .rst_i           (rst),
        .trn_lnk_up_n_i  (lnk_n),
        .module_rdy_i    (rdy),
        .usr_rst_req_i   (req),
        .usr_rst_o       (usr_rst),
        .link_ok_o       (link_ok),
        .train_tmo_o     (train_tmo),
        .sys_reset_req_o (sys_req),
        .lnk_down_cnt_o  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int drops);
`ifdef PCIE_LNKMON_CNT_EN
        return (drops > 255) ? 32'd255 : 32'(drops);
`else
        return (drops > 255) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        rst   = 1'b1;
        lnk_n = 1'b1;
        rdy   = 1'b0;
        req   = 1'b0;

        // Reset values
        tick(3);
        chk("rst_usr_rst", usr_rst, 1);
        chk("rst_link_ok", link_ok, 0);
        chk("rst_train_tmo", train_tmo, 0);
        chk("rst_sys_req", sys_req, 0);
        chk("rst_cnt", cnt, 0);

        // Link-up latency of 83 cycles
        rst = 1'b0;
        rdy = 1'b1;
        tick(5);
        lnk_n = 1'b0;
        tick(82);
        chk("t1_ok_at82", link_ok, 0);
        chk("t1_usr_rst_at82", usr_rst, 1);
        tick(1);
        chk("t1_ok_at83", link_ok, 1);
        chk("t1_usr_rst_at83", usr_rst, 0);
        chk("t1_cnt", cnt, 0);
        chk("t1_tmo", train_tmo, 0);

        // User reset request while up
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("t5_req_usr_rst", usr_rst, 1);
        chk("t5_req_ok", link_ok, 0);
        tick(63);
        chk("t5_req_usr_rst_63", usr_rst, 1);
        tick(1);
        chk("t5_req_usr_rst_64", usr_rst, 0);
        chk("t5_req_ok_64", link_ok, 1);

        // Request coincident with link loss: loss wins and is counted
        lnk_n = 1'b1;
        tick(2);
        chk("t5_sync_latency_ok", link_ok, 1);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("t5_loss_usr_rst", usr_rst, 1);
        chk("t5_loss_ok", link_ok, 0);
        chk("t5_loss_cnt", cnt, exp_cnt(1));

        // 300 drops from ST_UP, counter saturates
        for (int i = 0; i < 300; i++) begin
            lnk_n = 1'b0;
            tick(83);
            chk("t4_up", link_ok, 1);
            lnk_n = 1'b1;
            tick(3);
            chk("t4_down", link_ok, 0);
            if (i == 252) chk("t4_cnt_254", cnt, exp_cnt(254));
            if (i == 253) chk("t4_cnt_255", cnt, exp_cnt(255));
            if (i == 299) chk("t4_cnt_sat", cnt, exp_cnt(301));
        end

        // Asynchronous reset in the middle of ST_RST
        lnk_n = 1'b0;
        tick(30);
        chk("t6_pre_usr_rst", usr_rst, 1);
        chk("t6_pre_ok", link_ok, 0);
        chk("t6_pre_cnt", cnt, exp_cnt(301));
        #3;
        rst = 1'b1;
        #1;
        chk("t6_usr_rst", usr_rst, 1);
        chk("t6_ok", link_ok, 0);
        chk("t6_tmo", train_tmo, 0);
        chk("t6_sys_req", sys_req, 0);
        chk("t6_cnt", cnt, 0);

        // Debounce glitch at debounce cycle 10 restarts the sequence
        tick(2);
        rst = 1'b0;
        tick(12);
        lnk_n = 1'b1;
        tick(1);
        lnk_n = 1'b0;
        tick(2);
        chk("t2_usr_rst_mid", usr_rst, 1);
        tick(68);
        chk("t2_ok_at_old83", link_ok, 0);
        tick(12);
        chk("t2_ok_at82", link_ok, 0);
        tick(1);
        chk("t2_ok_at83", link_ok, 1);
        chk("t2_usr_rst_at83", usr_rst, 0);

        // Training timeout with repeated core-reset pulses
        rst   = 1'b1;
        lnk_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(199);
        chk("t3_req_199", sys_req, 0);
        chk("t3_tmo_199", train_tmo, 0);
        tick(1);
        chk("t3_req_200", sys_req, 1);
        chk("t3_tmo_200", train_tmo, 1);
        tick(1);
        chk("t3_req_201", sys_req, 0);
        chk("t3_tmo_201", train_tmo, 1);
        tick(198);
        chk("t3_req_399", sys_req, 0);
        tick(1);
        chk("t3_req_400", sys_req, 1);
        tick(199);
        chk("t3_req_599", sys_req, 0);
        tick(1);
        chk("t3_req_600", sys_req, 1);
        tick(1);
        chk("t3_req_601", sys_req, 0);
        lnk_n = 1'b0;
        tick(82);
        chk("t3_ok_at82", link_ok, 0);
        chk("t3_tmo_at82", train_tmo, 1);
        tick(1);
        chk("t3_ok_at83", link_ok, 1);
        chk("t3_tmo_at83", train_tmo, 0);

        // Link seen on the same cycle the WAIT timeout expires
        rst   = 1'b1;
        lnk_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(197);
        lnk_n = 1'b0;
        tick(3);
        chk("race_req_200", sys_req, 0);
        chk("race_tmo_200", train_tmo, 0);
        tick(79);
        chk("race_ok_279", link_ok, 0);
        tick(1);
        chk("race_ok_280", link_ok, 1);
        chk("race_tmo_280", train_tmo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
